// File: rtl/maniobra_seq.sv
// Timed manoeuvre sequencer feeding the wheel-direction decoder: one pending slot, reversal dead-time.
// Optional macro OBSTACLE_STOP_EN adds an obstacle input that cuts forward runs short.
module maniobra_seq #(
    parameter int CLK_HZ  = 100000000,
    parameter int DEAD_MS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_move,
    input  logic [15:0] cmd_ms,
    input  logic        abort,
`ifdef OBSTACLE_STOP_EN
    input  logic        obstacle,
`endif
    output logic [2:0]  move,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] remaining_ms
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int DEAD_CYC = DEAD_MS * TICK_DIV;
    localparam int CNT_MAX  = (DEAD_CYC > TICK_DIV) ? DEAD_CYC : TICK_DIV;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [2:0] MOVE_FWD  = 3'b000;
    localparam logic [2:0] MOVE_STOP = 3'b011;

    typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] presc;
    logic             pend_valid;
    logic [2:0]       pend_move;
    logic [15:0]      pend_ms;
    logic [2:0]       cur_move;
    logic [15:0]      cur_ms;
    logic [2:0]       prev_move;
    logic             prev_valid;

    logic accept, pend_bad, pend_runnable, pend_rev;
    logic ms_tick, run_final, obstacle_hit, start_cmd;

    // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on the pending slot and abort, never on cmd_valid.
    assign cmd_ready = !pend_valid && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || pend_valid;

    assign pend_bad      = pend_move[2] && pend_move[1];
    assign pend_runnable = pend_valid && !pend_bad && (pend_ms != 16'd0);
    // Codes 100/101 are the only valid codes with bit 2 set, so bit 2 marks spin/reverse.
    assign pend_rev      = prev_valid && (pend_move != MOVE_STOP) && (pend_move != prev_move)
                           && (pend_move[2] || prev_move[2]);

    assign ms_tick   = (presc == TICK_LAST);
    assign run_final = (state == RUN) && ms_tick && (remaining_ms == 16'd1);

`ifdef OBSTACLE_STOP_EN
    assign obstacle_hit = (state == RUN) && (move == MOVE_FWD) && obstacle;
`else
    assign obstacle_hit = 1'b0;
`endif

    // Invalid or zero-length commands are left for IDLE so each one gets its own done pulse.
    assign start_cmd = pend_runnable && !obstacle_hit && ((state == IDLE) || run_final);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            move         <= MOVE_STOP;
            done         <= 1'b0;
            err          <= 1'b0;
            remaining_ms <= 16'd0;
            presc        <= '0;
            pend_valid   <= 1'b0;
            pend_move    <= MOVE_STOP;
            pend_ms      <= 16'd0;
            cur_move     <= MOVE_STOP;
            cur_ms       <= 16'd0;
            prev_move    <= MOVE_STOP;
            prev_valid   <= 1'b0;
        end else if (abort) begin
            state        <= IDLE;
            move         <= MOVE_STOP;
            done         <= 1'b0;
            remaining_ms <= 16'd0;
            presc        <= '0;
            pend_valid   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                pend_valid <= 1'b1;
                pend_move  <= cmd_move;
                pend_ms    <= cmd_ms;
                if (!(cmd_move[2] && cmd_move[1]))
                    err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pend_valid && !pend_runnable) begin
                        pend_valid <= 1'b0;
                        done       <= 1'b1;
                        if (pend_bad)
                            err <= 1'b1;
                    end
                end
                DEAD: begin
                    if (presc == DEAD_LAST) begin
                        state        <= RUN;
                        move         <= cur_move;
                        remaining_ms <= cur_ms;
                        presc        <= '0;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                RUN: begin
                    if (obstacle_hit) begin
                        state        <= IDLE;
                        move         <= MOVE_STOP;
                        done         <= 1'b1;
                        err          <= 1'b1;
                        remaining_ms <= 16'd0;
                        presc        <= '0;
                        pend_valid   <= 1'b0;
                    end else if (ms_tick) begin
                        presc <= '0;
                        if (remaining_ms != 16'd0)
                            remaining_ms <= remaining_ms - 16'd1;
                        if (run_final) begin
                            done  <= 1'b1;
                            state <= IDLE;
                            move  <= MOVE_STOP;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Pop overrides the IDLE/end-of-run defaults so back-to-back moves have no stop gap.
            if (start_cmd) begin
                pend_valid <= 1'b0;
                cur_move   <= pend_move;
                cur_ms     <= pend_ms;
                presc      <= '0;
                if (pend_move != MOVE_STOP) begin
                    prev_move  <= pend_move;
                    prev_valid <= 1'b1;
                end
                if (pend_rev) begin
                    state        <= DEAD;
                    move         <= MOVE_STOP;
                    remaining_ms <= 16'd0;
                end else begin
                    state        <= RUN;
                    move         <= pend_move;
                    remaining_ms <= pend_ms;
                end
            end
        end
    end

endmodule

// File: tb/tb_maniobra_seq.sv
// Directed bench for maniobra_seq with CLK_HZ=10000 (10 cycles/ms) and DEAD_MS=2 (20 dead cycles).
// Inputs change and outputs are sampled on the falling edge; done pulses are tallied on the rising edge.
module tb_maniobra_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_move = 3'b011;
    logic [15:0] cmd_ms = 16'd0;
    logic        abort = 1'b0;
`ifdef OBSTACLE_STOP_EN
    logic        obstacle = 1'b0;
`endif
    logic [2:0]  move;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] remaining_ms;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int d0;

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    maniobra_seq #(.CLK_HZ(10000), .DEAD_MS(2)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_move(cmd_move),
        .cmd_ms(cmd_ms),
        .abort(abort),
`ifdef OBSTACLE_STOP_EN
        .obstacle(obstacle),
`endif
        .move(move),
        .busy(busy),
        .done(done),
        .err(err),
        .remaining_ms(remaining_ms)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offers a command, waits (bounded) for cmd_ready, returns on the falling edge after the transfer.
    task automatic send(input logic [2:0] m, input logic [15:0] ms);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_move  = m;
        cmd_ms    = ms;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", {31'd0, cmd_ready}, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_move  = 3'b011;
        cmd_ms    = 16'd0;
    endtask

    // Counts consecutive sampled cycles with move == m, starting at the current falling edge.
    task automatic seg(input logic [2:0] m, input int len, input string tag);
        int n;
        n = 0;
        while (move === m && n < 200) begin
            n++;
            tick();
        end
        chk(tag, n, len);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_move", move, 3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rem", remaining_ms, 0);
        chk("rst_ready", cmd_ready, 1);
        rst = 1'b0;
        tick();

        // single forward run of 3 ms
        d0 = done_cnt;
        send(3'b000, 16'd3);
        chk("t1_move_before_latency", move, 3);
        chk("t1_busy_pending", busy, 1);
        tick();
        chk("t1_rem_load", remaining_ms, 3);
        seg(3'b000, 30, "t1_fwd_len");
        chk("t1_done_pulse", done, 1);
        chk("t1_stop_after", move, 3);
        chk("t1_rem_zero", remaining_ms, 0);
        tick();
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t1_busy_end", busy, 0);

        // back-to-back fwd 2 ms then right 1 ms; 000 already showing when second send returns
        d0 = done_cnt;
        send(3'b000, 16'd2);
        send(3'b001, 16'd1);
        seg(3'b000, 19, "t2_fwd_len");
        chk("t2_no_gap", move, 1);
        seg(3'b001, 10, "t2_right_len");
        tick();
        chk("t2_done_count", done_cnt - d0, 2);

        // fwd then reverse: dead-time of 20 cycles between them
        d0 = done_cnt;
        send(3'b000, 16'd1);
        send(3'b101, 16'd1);
        seg(3'b000, 9, "t3_fwd_len");
        chk("t3_done_after_fwd", done, 1);
        seg(3'b011, 20, "t3_dead_len");
        seg(3'b101, 10, "t3_rev_len");
        chk("t3_done_after_rev", done, 1);
        tick();
        chk("t3_done_count", done_cnt - d0, 2);

        // invalid code sets err, then a valid command clears it on accept
        send(3'b110, 16'd5);
        tick();
        chk("t4_err_set", err, 1);
        chk("t4_done_invalid", done, 1);
        chk("t4_move_kept", move, 3);
        chk("t4_busy_invalid", busy, 0);
        send(3'b010, 16'd1);
        chk("t4_err_clear", err, 0);
        tick();
        seg(3'b011, 20, "t4_dead_len");
        seg(3'b010, 10, "t4_left_len");

        // zero duration completes without moving
        tick();
        send(3'b000, 16'd0);
        tick();
        chk("t5_zero_done", done, 1);
        chk("t5_zero_move", move, 3);
        chk("t5_zero_busy", busy, 0);

        // abort mid-run with a queued command
        send(3'b000, 16'd5);
        send(3'b001, 16'd5);
        repeat (12) tick();
        chk("t6_move_run", move, 0);
        chk("t6_rem_mid", remaining_ms, 4);
        chk("t6_busy_run", busy, 1);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        chk("t6_abort_move", move, 3);
        chk("t6_abort_rem", remaining_ms, 0);
        chk("t6_abort_busy", busy, 0);
        chk("t6_abort_done", done, 0);
        cmd_valid = 1'b1;
        cmd_move  = 3'b000;
        cmd_ms    = 16'd1;
        chk("t6_ready_abort", cmd_ready, 0);
        tick();
        abort = 1'b0;
        cmd_valid = 1'b0;
        chk("t6_no_accept", busy, 0);
        repeat (5) tick();
        chk("t6_pending_dropped", move, 3);
        chk("t6_no_done", done_cnt - d0, 0);

        // synchronous reset mid-run
        send(3'b001, 16'd5);
        tick();
        chk("t7_move_run", move, 1);
        send(3'b000, 16'd3);
        tick();
        rst = 1'b1;
        tick();
        chk("t7_rst_move", move, 3);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_rem", remaining_ms, 0);
        chk("t7_rst_ready", cmd_ready, 1);
        rst = 1'b0;
        repeat (3) tick();
        chk("t7_idle_move", move, 3);
        chk("t7_idle_busy", busy, 0);

`ifdef OBSTACLE_STOP_EN
        // obstacle cuts a forward run short; reverse ignores it
        send(3'b000, 16'd5);
        repeat (11) tick();
        obstacle = 1'b1;
        tick();
        obstacle = 1'b0;
        chk("t8_obst_move", move, 3);
        chk("t8_obst_done", done, 1);
        chk("t8_obst_err", err, 1);
        send(3'b101, 16'd5);
        repeat (22) tick();
        obstacle = 1'b1;
        tick();
        obstacle = 1'b0;
        chk("t8_rev_ignores", move, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
